// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes RISC-V R/I/load-store/branch encodings into ALU
// control codes and sequences multi-cycle M-extension ops with a latency counter.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [1:0]      alu_op,
  input  logic            alu_en_n,
  input  logic            flush,
  output logic            out_valid,
  output logic [OP_W-1:0] operation,
  output logic [1:0]      equal_comp,
  output logic [2:0]      mem,
  output logic            illegal,
  output logic            md_start,
  output logic            md_busy
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SLTU = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t            state_q;
  logic [5:0]        cnt_q;
  logic              outValid_q;
  logic [OP_W-1:0]   operation_q;
  logic [1:0]        equalComp_q;
  logic [2:0]        mem_q;
  logic              illegal_q;
  logic              mdStart_q;
  logic              mdBusy_q;

  logic [4:0]        decOp_d;
  logic [1:0]        decEq_d;
  logic [2:0]        decMem_d;
  logic              decIll_d;
  logic              decIsM_d;
  logic [5:0]        latCnt_d;
  logic              accept;

  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              unusedInstr;

  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign unusedInstr = ^{instr[24:15], instr[11:0]};

  assign in_ready = (state_q == IDLE) & ~alu_en_n & ~flush;
  assign accept   = in_valid & in_ready;
  assign latCnt_d = funct3[2] ? DIV_CNT : MUL_CNT;

  // Anything not recognised falls through to ADD with the illegal flag set
  always_comb begin
    decOp_d  = OP_ADD;
    decEq_d  = 2'b00;
    decMem_d = 3'b000;
    decIll_d = 1'b0;
    decIsM_d = 1'b0;
    case (alu_op)
      2'b00: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  decOp_d = OP_ADD;
            3'b001:  decOp_d = OP_SLL;
            3'b010:  decOp_d = OP_SLT;
            3'b011:  decOp_d = OP_SLTU;
            3'b100:  decOp_d = OP_XOR;
            3'b101:  decOp_d = OP_SRL;
            3'b110:  decOp_d = OP_OR;
            default: decOp_d = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          decOp_d = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          decOp_d = OP_SRA;
        end else if (funct7 == 7'b0000001) begin
          decOp_d  = {2'b10, funct3};
          decIsM_d = 1'b1;
        end else begin
          decIll_d = 1'b1;
        end
      end
      2'b01: begin
        case (funct3)
          3'b000:  decOp_d = OP_ADD;
          3'b010:  decOp_d = OP_SLT;
          3'b011:  decOp_d = OP_SLTU;
          3'b100:  decOp_d = OP_XOR;
          3'b110:  decOp_d = OP_OR;
          3'b111:  decOp_d = OP_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) decOp_d = OP_SLL;
            else                      decIll_d = 1'b1;
          end
          default: begin
            if (funct7 == 7'b0000000)      decOp_d = OP_SRL;
            else if (funct7 == 7'b0100000) decOp_d = OP_SRA;
            else                           decIll_d = 1'b1;
          end
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000:  decMem_d = 3'b001;
          3'b001:  decMem_d = 3'b010;
          3'b010:  decMem_d = 3'b011;
          3'b100:  decMem_d = 3'b100;
          3'b101:  decMem_d = 3'b101;
          default: decIll_d = 1'b1;
        endcase
      end
      default: begin
        case (funct3)
          3'b000: begin decOp_d = OP_SUB;  decEq_d = 2'b11; end
          3'b001: begin decOp_d = OP_SUB;  decEq_d = 2'b10; end
          3'b100: begin decOp_d = OP_SLT;  decEq_d = 2'b10; end
          3'b101: begin decOp_d = OP_SLT;  decEq_d = 2'b11; end
          3'b110: begin decOp_d = OP_SLTU; decEq_d = 2'b10; end
          3'b111: begin decOp_d = OP_SLTU; decEq_d = 2'b11; end
          default: decIll_d = 1'b1;
        endcase
      end
    endcase
  end

  // Control fields latch at accept and stay put until the next accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      outValid_q  <= 1'b0;
      operation_q <= '0;
      equalComp_q <= 2'b00;
      mem_q       <= 3'b000;
      illegal_q   <= 1'b0;
      mdStart_q   <= 1'b0;
      mdBusy_q    <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      mdStart_q  <= 1'b0;
      if (flush) begin
        state_q  <= IDLE;
        mdBusy_q <= 1'b0;
        cnt_q    <= 6'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              operation_q <= OP_W'(decOp_d);
              equalComp_q <= decEq_d;
              mem_q       <= decMem_d;
              illegal_q   <= decIll_d;
              if (decIsM_d) begin
                state_q   <= MD_WAIT;
                mdStart_q <= 1'b1;
                mdBusy_q  <= 1'b1;
                cnt_q     <= latCnt_d;
              end else begin
                outValid_q <= 1'b1;
              end
            end
          end
          MD_WAIT: begin
            if (cnt_q != 6'd0) begin
              cnt_q <= cnt_q - 6'd1;
            end else begin
              outValid_q <= 1'b1;
              mdBusy_q   <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid  = outValid_q;
  assign operation  = operation_q;
  assign equal_comp = equalComp_q;
  assign mem        = mem_q;
  assign illegal    = illegal_q;
  assign md_start   = mdStart_q;
  assign md_busy    = mdBusy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with hand-computed control codes and M-op latencies.
module tb_alu_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [1:0]  alu_op;
  logic        alu_en_n;
  logic        flush;
  logic        out_valid;
  logic [4:0]  operation;
  logic [1:0]  equal_comp;
  logic [2:0]  mem;
  logic        illegal;
  logic        md_start;
  logic        md_busy;

  int vecCount  = 0;
  int missCount = 0;

  alu_ctrl_seq #(.MUL_LAT(2), .DIV_LAT(4), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_op(alu_op), .alu_en_n(alu_en_n), .flush(flush),
    .out_valid(out_valid), .operation(operation), .equal_comp(equal_comp),
    .mem(mem), .illegal(illegal), .md_start(md_start), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for exactly one edge; returns 1ns after that edge
  task automatic applyStimulus(input logic [31:0] ins, input logic [1:0] op);
    @(negedge clk);
    instr    = ins;
    alu_op   = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkDecode(input string tag, input logic [4:0] op, input logic [1:0] eq,
                             input logic [2:0] mw, input logic ill);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".op"},    32'(operation), 32'(op));
    checkOutput({tag, ".eq"},    32'(equal_comp), 32'(eq));
    checkOutput({tag, ".mem"},   32'(mem), 32'(mw));
    checkOutput({tag, ".ill"},   32'(illegal), 32'(ill));
    checkOutput({tag, ".start"}, 32'(md_start), 32'd0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; alu_op = 2'b00;
    alu_en_n = 1'b0; flush = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.busy",  32'(md_busy), 32'd0);
    checkOutput("rst.start", 32'(md_start), 32'd0);
    checkOutput("rst.op",    32'(operation), 32'd0);
    checkOutput("rst.ill",   32'(illegal), 32'd0);
    checkOutput("rst.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle decodes
    applyStimulus(32'h40B50533, 2'b00); checkDecode("sub",   5'b00011, 2'b00, 3'b000, 1'b0);
    applyStimulus(32'h00B51463, 2'b11); checkDecode("bne",   5'b00011, 2'b10, 3'b000, 1'b0);
    applyStimulus(32'h00B54463, 2'b11); checkDecode("blt",   5'b00101, 2'b10, 3'b000, 1'b0);
    applyStimulus(32'h00B50463, 2'b11); checkDecode("beq",   5'b00011, 2'b11, 3'b000, 1'b0);
    applyStimulus(32'h00B52463, 2'b11); checkDecode("bill",  5'b00010, 2'b00, 3'b000, 1'b1);
    applyStimulus(32'h00051503, 2'b10); checkDecode("lh",    5'b00010, 2'b00, 3'b010, 1'b0);
    applyStimulus(32'h00053503, 2'b10); checkDecode("ldill", 5'b00010, 2'b00, 3'b000, 1'b1);
    applyStimulus(32'h40055513, 2'b01); checkDecode("srai",  5'b01001, 2'b00, 3'b000, 1'b0);
    applyStimulus(32'h40051513, 2'b01); checkDecode("slli7", 5'b00010, 2'b00, 3'b000, 1'b1);
    applyStimulus(32'h00B54533, 2'b00); checkDecode("xor",   5'b00110, 2'b00, 3'b000, 1'b0);
    applyStimulus(32'h00B57533, 2'b00); checkDecode("and",   5'b00000, 2'b00, 3'b000, 1'b0);
    stepCycle();
    checkOutput("b2b.drop", 32'(out_valid), 32'd0);

    // DIV with DIV_LAT=4: busy four cycles, result in the fifth
    applyStimulus(32'h02B54533, 2'b00);
    checkOutput("div.start", 32'(md_start), 32'd1);
    checkOutput("div.busy",  32'(md_busy), 32'd1);
    checkOutput("div.ready1", 32'(in_ready), 32'd0);
    checkOutput("div.valid1", 32'(out_valid), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      stepCycle();
      checkOutput($sformatf("div.ready%0d", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("div.valid%0d", k), 32'(out_valid), 32'd0);
      checkOutput($sformatf("div.start%0d", k), 32'(md_start), 32'd0);
    end
    stepCycle();
    checkOutput("div.valid5", 32'(out_valid), 32'd1);
    checkOutput("div.op",     32'(operation), 32'b10100);
    checkOutput("div.busy5",  32'(md_busy), 32'd0);
    checkOutput("div.ready5", 32'(in_ready), 32'd1);
    stepCycle();
    checkOutput("div.valid6", 32'(out_valid), 32'd0);

    // MUL completes while decode is disabled; the held request is not taken
    applyStimulus(32'h02B50533, 2'b00);
    checkOutput("mul.start", 32'(md_start), 32'd1);
    @(negedge clk);
    alu_en_n = 1'b1; in_valid = 1'b1; instr = 32'h40B50533; alu_op = 2'b00;
    stepCycle();
    checkOutput("mul.valid2", 32'(out_valid), 32'd0);
    stepCycle();
    checkOutput("mul.valid3", 32'(out_valid), 32'd1);
    checkOutput("mul.op",     32'(operation), 32'b10000);
    checkOutput("en.ready",   32'(in_ready), 32'd0);
    stepCycle();
    checkOutput("en.noacc",   32'(out_valid), 32'd0);
    @(negedge clk);
    alu_en_n = 1'b0; in_valid = 1'b0;

    // Flush two cycles after MUL accept, with a competing request
    applyStimulus(32'h02B50533, 2'b00);
    stepCycle();
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h40B50533;
    checkOutput("fl.ready", 32'(in_ready), 32'd0);
    stepCycle();
    checkOutput("fl.busy",  32'(md_busy), 32'd0);
    checkOutput("fl.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    stepCycle();
    checkOutput("fl.valid2", 32'(out_valid), 32'd0);
    checkOutput("fl.op",     32'(operation), 32'b10000);

    // Reset two cycles after MUL accept
    applyStimulus(32'h02B50533, 2'b00);
    stepCycle();
    @(negedge clk);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("mrst.busy",  32'(md_busy), 32'd0);
    checkOutput("mrst.valid", 32'(out_valid), 32'd0);
    checkOutput("mrst.op",    32'(operation), 32'd0);
    checkOutput("mrst.eq",    32'(equal_comp), 32'd0);
    checkOutput("mrst.mem",   32'(mem), 32'd0);
    checkOutput("mrst.ill",   32'(illegal), 32'd0);
    checkOutput("mrst.start", 32'(md_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("mrst.valid2", 32'(out_valid), 32'd0);
    checkOutput("mrst.ready",  32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
